// File: rtl/draw_pkg.sv
// -----------------------------------------------------------------------------
// draw_pkg
// Shared definitions for the draw scheduler slice: scheduler state encoding,
// VGA screen geometry and pixel field widths, plus a small index helper used
// by the round-robin picker.
// -----------------------------------------------------------------------------
package draw_pkg;

  // Scheduler states; encodings are fixed so debug probes decode consistently.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WARM  = 2'd1,
    ST_DRAW  = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  // VGA adapter geometry and pixel field widths.
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 9;

  // Engine index reached by stepping 'off' places past 'base' around a ring of
  // 'n' engines. Used to walk requests starting just after the last winner.
  function automatic int unsigned ring_index(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/draw_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Scans req starting at
// last_id+1 and wrapping modulo NUM_REQ; the first set bit wins, so the
// previous winner has the lowest priority on the next pick.
//
// Ports:
//   req      in  NUM_REQ  request vector
//   last_id  in  ID_W     index of the most recently serviced engine
//   winner   out ID_W     index of the chosen engine (0 when nothing requests)
//   any      out 1        at least one request bit is set
// -----------------------------------------------------------------------------
module rr_pick
  import draw_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    winner,
  output logic               any
);

  logic [ID_W-1:0] idx_s;
  logic [ID_W-1:0] winner_s;
  logic            any_s;

  // Walk the ring once; the offset NUM_REQ lands back on last_id, so the
  // previous winner is only chosen when it is the sole requester.
  always_comb begin
    idx_s    = {ID_W{1'b0}};
    winner_s = {ID_W{1'b0}};
    any_s    = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx_s = ID_W'(ring_index(int'(last_id), off, NUM_REQ));
      if (!any_s && req[idx_s]) begin
        winner_s = idx_s;
        any_s    = 1'b1;
      end else begin
        any_s    = any_s;
      end
    end
  end

  assign winner = winner_s;
  assign any    = any_s;

endmodule

// File: rtl/draw_scheduler.sv
// -----------------------------------------------------------------------------
// draw_scheduler
// Shares the single VGA adapter write port among NUM_REQ draw engines.
// One engine is granted at a time: its enable is raised, the first
// SKIP_CYCLES cycles (engine start plus ROM read latency) are absorbed with
// plot held low, then the engine's x/y/colour are muxed onto the VGA port
// with plot high every cycle until the engine reports done. Because engine
// done flags are sticky, the scheduler then pulses that engine's local
// active-low clear for one cycle before returning to IDLE. A draw that never
// finishes is aborted after TIMEOUT_CYCLES and flagged in timeout_err.
//
// Ports:
//   clk             in  1            system clock
//   resetn          in  1            synchronous active-low reset
//   req             in  NUM_REQ      level request per engine
//   done            in  NUM_REQ      sticky engine done flags
//   pix_x_bus       in  8*NUM_REQ    engine x, engine i at [8i+7:8i]
//   pix_y_bus       in  7*NUM_REQ    engine y, engine i at [7i+6:7i]
//   pix_colour_bus  in  9*NUM_REQ    engine colour, engine i at [9i+8:9i]
//   en              out NUM_REQ      one-hot engine enable
//   clr_n           out NUM_REQ      one-cycle active-low engine clear
//   vga_x           out 8            VGA x
//   vga_y           out 7            VGA y
//   vga_colour      out 9            VGA colour
//   vga_plot        out 1            VGA write strobe
//   busy            out 1            scheduler not idle
//   active_id       out ID_W         index of the granted engine
//   timeout_err     out 1            sticky abort flag
// -----------------------------------------------------------------------------
module draw_scheduler
  import draw_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = 2,
  parameter int SKIP_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ-1:0]          done,
  input  logic [X_W*NUM_REQ-1:0]      pix_x_bus,
  input  logic [Y_W*NUM_REQ-1:0]      pix_y_bus,
  input  logic [COLOUR_W*NUM_REQ-1:0] pix_colour_bus,
  output logic [NUM_REQ-1:0]          en,
  output logic [NUM_REQ-1:0]          clr_n,
  output logic [X_W-1:0]              vga_x,
  output logic [Y_W-1:0]              vga_y,
  output logic [COLOUR_W-1:0]         vga_colour,
  output logic                        vga_plot,
  output logic                        busy,
  output logic [ID_W-1:0]             active_id,
  output logic                        timeout_err
);

  // Counter must reach both SKIP_CYCLES-1 and TIMEOUT_CYCLES-1.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SKIP_CYCLES) ? TIMEOUT_CYCLES : SKIP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SKIP_LAST    = CNT_W'(SKIP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID_RST  = ID_W'(NUM_REQ - 1);

  state_t              state_r;
  logic [ID_W-1:0]     active_id_r;
  logic [ID_W-1:0]     last_id_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                timeout_err_r;

  logic [ID_W-1:0]     winner_s;
  logic                any_s;
  logic                done_act_s;

  logic [NUM_REQ-1:0]  en_s;
  logic [NUM_REQ-1:0]  clr_n_s;
  logic [X_W-1:0]      x_s;
  logic [Y_W-1:0]      y_s;
  logic [COLOUR_W-1:0] colour_s;
  logic                plot_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (req),
    .last_id (last_id_r),
    .winner  (winner_s),
    .any     (any_s)
  );

  // Only the granted engine's done flag matters; others are ignored.
  assign done_act_s = done[active_id_r];

  // Grant / warm-up / draw / clear sequencing with the draw-cycle watchdog.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r       <= ST_IDLE;
      active_id_r   <= {ID_W{1'b0}};
      last_id_r     <= LAST_ID_RST;
      cnt_r         <= {CNT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_s) begin
            active_id_r <= winner_s;
            cnt_r       <= {CNT_W{1'b0}};
            state_r     <= ST_WARM;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_WARM: begin
          // A done already high here is left over from an earlier draw.
          if (done_act_s) begin
            state_r <= ST_CLEAR;
          end else if (cnt_r == SKIP_LAST) begin
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= ST_DRAW;
          end else begin
            cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_DRAW: begin
          if (done_act_s) begin
            state_r <= ST_CLEAR;
          end else if (cnt_r == TIMEOUT_LAST) begin
            timeout_err_r <= 1'b1;
            state_r       <= ST_CLEAR;
          end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_CLEAR: begin
          last_id_r <= active_id_r;
          state_r   <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from the registered state and grant index.
  always_comb begin
    en_s     = {NUM_REQ{1'b0}};
    clr_n_s  = {NUM_REQ{1'b1}};
    plot_s   = 1'b0;
    x_s      = {X_W{1'b0}};
    y_s      = {Y_W{1'b0}};
    colour_s = {COLOUR_W{1'b0}};

    // Pixel mux always follows active_id; plot alone qualifies it.
    for (int i = 0; i < NUM_REQ; i++) begin
      if (active_id_r == ID_W'(i)) begin
        x_s      = pix_x_bus[i*X_W +: X_W];
        y_s      = pix_y_bus[i*Y_W +: Y_W];
        colour_s = pix_colour_bus[i*COLOUR_W +: COLOUR_W];
      end else begin
        x_s      = x_s;
      end
    end

    case (state_r)
      ST_IDLE: begin
        en_s = {NUM_REQ{1'b0}};
      end
      ST_WARM: begin
        en_s[active_id_r] = 1'b1;
      end
      ST_DRAW: begin
        en_s[active_id_r] = 1'b1;
        plot_s            = 1'b1;
      end
      ST_CLEAR: begin
        clr_n_s[active_id_r] = 1'b0;
      end
      default: begin
        en_s = {NUM_REQ{1'b0}};
      end
    endcase
  end

  assign en          = en_s;
  assign clr_n       = clr_n_s;
  assign vga_x       = x_s;
  assign vga_y       = y_s;
  assign vga_colour  = colour_s;
  assign vga_plot    = plot_s;
  assign busy        = (state_r != ST_IDLE);
  assign active_id   = active_id_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_draw_scheduler.sv
// -----------------------------------------------------------------------------
// tb_draw_scheduler
// Self-checking bench for draw_scheduler with four model engines that each
// draw 20 pixels after a 2-cycle start delay. Stimulus pushes expected grants,
// warm-up lengths, pixels and clears into queues; a negedge monitor pops and
// compares whenever the DUT grants, plots or clears.
// -----------------------------------------------------------------------------
module tb_draw_scheduler;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int SKIP    = 2;
  localparam int TMO     = 50;
  localparam int NPIX    = 20;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic [NUM_REQ-1:0]  req = 4'b0000;
  logic [NUM_REQ-1:0]  done;
  logic [8*NUM_REQ-1:0] pix_x_bus;
  logic [7*NUM_REQ-1:0] pix_y_bus;
  logic [9*NUM_REQ-1:0] pix_colour_bus;
  logic [NUM_REQ-1:0]  en;
  logic [NUM_REQ-1:0]  clr_n;
  logic [7:0]          vga_x;
  logic [6:0]          vga_y;
  logic [8:0]          vga_colour;
  logic                vga_plot;
  logic                busy;
  logic [ID_W-1:0]     active_id;
  logic                timeout_err;

  draw_scheduler #(
    .NUM_REQ        (NUM_REQ),
    .ID_W           (ID_W),
    .SKIP_CYCLES    (SKIP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .req            (req),
    .done           (done),
    .pix_x_bus      (pix_x_bus),
    .pix_y_bus      (pix_y_bus),
    .pix_colour_bus (pix_colour_bus),
    .en             (en),
    .clr_n          (clr_n),
    .vga_x          (vga_x),
    .vga_y          (vga_y),
    .vga_colour     (vga_colour),
    .vga_plot       (vga_plot),
    .busy           (busy),
    .active_id      (active_id),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  // ---------------- model engines ----------------
  logic [7:0]         ecnt [NUM_REQ];
  logic [NUM_REQ-1:0] done_m;
  logic [NUM_REQ-1:0] never_done = 4'b0000;
  logic [NUM_REQ-1:0] stale = 4'b0000;
  logic [7:0]         pix_t;

  assign done = done_m;

  // Engine cycle counter and sticky done, cleared by resetn or clr_n.
  always @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!resetn || !clr_n[i]) begin
        ecnt[i]   <= 8'd0;
        done_m[i] <= 1'b0;
      end else begin
        if (stale[i])
          done_m[i] <= 1'b1;
        else if (en[i] && !never_done[i] && ecnt[i] == 8'(SKIP + NPIX - 2))
          done_m[i] <= 1'b1;
        if (en[i] && ecnt[i] != 8'hff)
          ecnt[i] <= ecnt[i] + 8'd1;
      end
    end
  end

  // Pixel p of engine i: x = 10i+p, y = i+p, colour = 100i+p.
  always_comb begin
    pix_t          = 8'd0;
    pix_x_bus      = '0;
    pix_y_bus      = '0;
    pix_colour_bus = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pix_t = ecnt[i] - 8'(SKIP);
      pix_x_bus[i*8 +: 8]      = 8'(i*10) + pix_t;
      pix_y_bus[i*7 +: 7]      = 7'(i) + pix_t[6:0];
      pix_colour_bus[i*9 +: 9] = 9'(i*100) + {1'b0, pix_t};
    end
  end

  function automatic logic [23:0] exp_pix(input int i, input int p);
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] c;
    x = 8'(i*10 + p);
    y = 7'(i + p);
    c = 9'(i*100 + p);
    return {x, y, c};
  endfunction

  // ---------------- scoreboard ----------------
  logic [23:0] plot_q [$];
  int          grant_q [$];
  int          clr_q [$];
  int          warm_q [$];

  int total = 0;
  int bad   = 0;
  bit mon_on  = 1'b0;
  bit gap_chk = 1'b0;
  int cyc = 0;
  int last_clr = -1;
  int warm_cnt = 0;
  int grants_seen = 0;
  logic [NUM_REQ-1:0] prev_en = 4'b0000;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_service(input int id, input int warm, input int npix);
    grant_q.push_back(id);
    warm_q.push_back(warm);
    for (int p = 0; p < npix; p++) plot_q.push_back(exp_pix(id, p));
    clr_q.push_back(id);
  endtask

  // Monitor: sampled on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    int idx;
    logic [23:0] e;
    if (mon_on) begin
      cyc++;
      idx = -1;
      for (int i = 0; i < NUM_REQ; i++) if (en[i]) idx = i;
      if (en != 4'b0000) check("en_onehot", $countones(en), 1);
      if (en != 4'b0000 && prev_en == 4'b0000) begin
        grants_seen++;
        warm_cnt = 0;
        if (grant_q.size() == 0) check("unexpected_grant", idx, -1);
        else check("grant_id", idx, grant_q.pop_front());
        check("active_id", int'(active_id), idx);
        if (gap_chk && last_clr >= 0) check("clear_gap", cyc - last_clr, 2);
      end
      if (en != 4'b0000 && !vga_plot) warm_cnt++;
      if (vga_plot) begin
        if (plot_q.size() == 0) check("unexpected_plot", int'(vga_x), -1);
        else begin
          e = plot_q.pop_front();
          check("vga_x", int'(vga_x), int'(e[23:16]));
          check("vga_y", int'(vga_y), int'(e[15:9]));
          check("vga_colour", int'(vga_colour), int'(e[8:0]));
        end
      end
      if (clr_n != 4'b1111) begin
        idx = -1;
        for (int i = 0; i < NUM_REQ; i++) if (!clr_n[i]) idx = i;
        check("clr_single", $countones(~clr_n), 1);
        if (clr_q.size() == 0) check("unexpected_clr", idx, -1);
        else check("clr_id", idx, clr_q.pop_front());
        if (warm_q.size() == 0) check("unexpected_warm", warm_cnt, -1);
        else check("warm_cycles", warm_cnt, warm_q.pop_front());
        last_clr = cyc;
      end
      prev_en = en;
    end
  end

  // ---------------- stimulus helpers ----------------
  // Run until all requests are served and the scheduler is idle. With
  // autodrop, each request is lowered once its engine is granted.
  task automatic serve(input string name, input int budget, input bit autodrop);
    int n = 0;
    bit fin = 1'b0;
    while (!fin && n < budget) begin
      @(posedge clk);
      #1;
      if (autodrop) req = req & ~en;
      stale = stale & clr_n;
      n++;
      fin = (req == 4'b0000) && !busy;
    end
    check(name, int'(fin), 1);
  endtask

  task automatic wait_plot_x(input string name, input logic [7:0] x, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk);
      n++;
      hit = vga_plot && (vga_x == x);
    end
    check(name, int'(hit), 1);
  endtask

  task automatic wait_grants(input int target, input int budget);
    int n = 0;
    while (grants_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_grants", int'(grants_seen >= target), 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_on = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_en", int'(en), 0);
    check("rst_clr_n", int'(clr_n), 15);
    check("rst_plot", int'(vga_plot), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_active_id", int'(active_id), 0);
    check("rst_timeout_err", int'(timeout_err), 0);

    // Round-robin with all requests held: 0,1,2,3,0
    expect_service(0, SKIP, NPIX);
    expect_service(1, SKIP, NPIX);
    expect_service(2, SKIP, NPIX);
    expect_service(3, SKIP, NPIX);
    expect_service(0, SKIP, NPIX);
    gap_chk = 1'b1;
    req = 4'b1111;
    wait_grants(grants_seen + 5, 600);
    req = 4'b0000;
    serve("rr_serve", 200, 1'b0);
    gap_chk = 1'b0;
    @(negedge clk);
    check("rr_busy_low", int'(busy), 0);

    // Single request on engine 0
    expect_service(0, SKIP, NPIX);
    @(posedge clk); #1;
    req = 4'b0001;
    serve("single_serve", 200, 1'b1);
    @(negedge clk);
    check("single_busy_low", int'(busy), 0);

    // Engine 2 granted; mid-draw its request drops and engine 1 requests
    expect_service(2, SKIP, NPIX);
    expect_service(1, SKIP, NPIX);
    @(posedge clk); #1;
    req = 4'b0100;
    wait_plot_x("contend_px5", exp_pix(2, 5) >> 16, 100);
    req = 4'b0010;
    serve("contend_serve", 300, 1'b1);

    // Stale done on engine 1: warm one cycle, no plots, then clear
    expect_service(1, 1, 0);
    @(posedge clk); #1;
    stale = 4'b0010;
    req   = 4'b0010;
    serve("stale_serve", 100, 1'b1);
    @(negedge clk);
    check("stale_no_timeout", int'(timeout_err), 0);

    // Reset at pixel 7 of engine 2: no clear pulse, pointer returns to 0
    grant_q.push_back(2);
    for (int p = 0; p < 8; p++) plot_q.push_back(exp_pix(2, p));
    @(posedge clk); #1;
    req = 4'b0100;
    wait_plot_x("rstmid_px7", exp_pix(2, 7) >> 16, 100);
    resetn = 1'b0;
    req    = 4'b0000;
    @(negedge clk);
    check("rstmid_en", int'(en), 0);
    check("rstmid_plot", int'(vga_plot), 0);
    check("rstmid_busy", int'(busy), 0);
    check("rstmid_clr_n", int'(clr_n), 15);
    check("rstmid_active_id", int'(active_id), 0);
    resetn = 1'b1;
    expect_service(0, SKIP, NPIX);
    expect_service(3, SKIP, NPIX);
    @(posedge clk); #1;
    req = 4'b1001;
    serve("rstmid_serve", 300, 1'b1);

    // Timeout: engine 3 never finishes, exactly TMO plots
    expect_service(3, SKIP, TMO);
    never_done = 4'b1000;
    @(posedge clk); #1;
    req = 4'b1000;
    serve("tmo_serve", 300, 1'b1);
    @(negedge clk);
    check("tmo_err_set", int'(timeout_err), 1);
    repeat (5) @(negedge clk);
    check("tmo_err_sticky", int'(timeout_err), 1);
    never_done = 4'b0000;

    // Reset clears the sticky flag
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("tmo_err_cleared", int'(timeout_err), 0);

    // Every expected event must have been observed
    repeat (3) @(negedge clk);
    check("plots_left", plot_q.size(), 0);
    check("grants_left", grant_q.size(), 0);
    check("clears_left", clr_q.size(), 0);
    check("warms_left", warm_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Round-robin scheduler that shares the single VGA adapter write port among up to NUM_REQ full-screen/sprite draw engines (WIN/LOSE screens, map background, tower sprites).
- Grants one engine at a time and drives its enable. Absorbs the engine's ROM pipeline fill, then muxes its x/y/colour onto the VGA port with a qualified plot.
- On the engine's done flag, pulses that engine's local clear, since engine done flags stay sticky until reset.
- Sits between the game FSM (which raises requests) and the VGA adapter.

Parameters:
- NUM_REQ, 4, number of draw engines; 2..8.
- ID_W, 2, width of active_id; equals clog2(NUM_REQ).
- SKIP_CYCLES, 2, enable-high cycles before the first valid pixel (engine start delay plus ROM read latency).
- TIMEOUT_CYCLES, 20000, maximum DRAW cycles before abort; exceeds 160x120 = 19200.

Ports:
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- req  in  NUM_REQ  level request per engine; held until serviced.
- done  in  NUM_REQ  engine done flags (sticky in engine).
- pix_x_bus  in  8*NUM_REQ  engine x; engine i at [8i+7:8i].
- pix_y_bus  in  7*NUM_REQ  engine y; engine i at [7i+6:7i].
- pix_colour_bus  in  9*NUM_REQ  engine colour; engine i at [9i+8:9i].
- en  out  NUM_REQ  one-hot engine enable.
- clr_n  out  NUM_REQ  active-low, one-cycle engine clear, ANDed with resetn at the engine.
- vga_x  out  8  to VGA adapter.
- vga_y  out  7  to VGA adapter.
- vga_colour  out  9  to VGA adapter.
- vga_plot  out  1  VGA write strobe.
- busy  out  1  high in any state except IDLE.
- active_id  out  ID_W  index of the granted engine.
- timeout_err  out  1  sticky abort flag.

Behaviour:
- Reset (resetn low at a clk edge):
  - state goes to IDLE; last_id <= NUM_REQ-1 so engine 0 wins first.
  - active_id <= 0; cnt <= 0; timeout_err <= 0.
  - Outputs during and after reset: en = 0, clr_n all 1, vga_plot = 0, busy = 0.
  - Reset mid-draw aborts immediately with no clear pulse; engines are reset by the global resetn.
- States: IDLE, WARM, DRAW, CLEAR. Outputs are decoded combinationally from the registered state and active_id.
- IDLE:
  - If req is nonzero, pick the first set bit scanning last_id+1, last_id+2, … modulo NUM_REQ.
  - Register active_id <= winner, cnt <= 0, go to WARM.
  - If req is zero, stay in IDLE.
- WARM:
  - en[active_id] = 1; vga_plot = 0.
  - cnt increments each cycle; after SKIP_CYCLES cycles in WARM go to DRAW and reset cnt to 0.
  - If done[active_id] = 1 in WARM, go directly to CLEAR (stale done).
- DRAW:
  - en[active_id] = 1.
  - vga_x/y/colour = the active_id slice of the buses; vga_plot = 1 every DRAW cycle, including the cycle where done[active_id] first reads 1, so the final pixel is written.
  - done[active_id] = 1 -> go to CLEAR next cycle.
  - Otherwise cnt increments; when cnt reaches TIMEOUT_CYCLES-1 without done, go to CLEAR and set timeout_err <= 1 (sticky until reset).
- CLEAR:
  - en = 0; vga_plot = 0; clr_n[active_id] = 0 for exactly this one cycle.
  - last_id <= active_id; go to IDLE.
- Minimum turnaround is done seen -> CLEAR -> IDLE -> WARM: the next grant's enable is high 3 cycles after done.
- Outside DRAW, vga_x/y/colour hold the active_id slice (don't-care; plot is low).
- Request changes:
  - Dropping req mid-service does not abort; the draw completes.
  - req changes outside IDLE are ignored until IDLE.
- At most one en bit is high in any cycle; a simultaneous done on a non-granted engine is ignored.

Decomposition:
- Shared package draw_pkg: state encodings (IDLE=0, WARM=1, DRAW=2, CLEAR=3) and constants SCREEN_W=160, SCREEN_H=120, X_W=8, Y_W=7, COLOUR_W=9.
- One sub-module rr_pick:
  - Combinational round-robin priority encoder.
  - Inputs: req, last_id. Outputs: winner, any.
  - Instantiated once.

Test Plan:
- Single request: bench with NUM_REQ=4, SKIP_CYCLES=2, model engines of 20 pixels; req=0001 -> en[0] high 2 cycles with plot low, then plot high for 20 cycles including the done cycle; clr_n[0] low 1 cycle; busy falls; vga_x/y track engine 0.
- Round-robin: req=1111 held -> grant order 0,1,2,3,0; each CLEAR-to-next-enable gap is exactly 2 cycles.
- Mid-draw drop and contention: engine 2 granted, req[2] dropped mid-draw, req[1] raised -> engine 2 completes all 20 plots; engine 1 granted next; en never has 2 bits high.
- Timeout: bench TIMEOUT_CYCLES=50, engine 3 never asserts done -> exactly 50 plot cycles, then CLEAR with clr_n[3] low, timeout_err=1 and held until resetn.
- Stale done: done[1] already high when granted -> WARM -> CLEAR with zero plot cycles.
- Reset mid-DRAW: resetn low for 1 cycle at pixel 7 -> next cycle en=0, plot=0, busy=0, no clr_n pulse; after release, req=0001 grants engine 0 first.
